// File: rtl/anc_pkg.sv
// anc_pkg -- shared definitions for the ANC MAC scheduler.
//   state_t        : scheduler FSM state encoding
//   NTAPS_DEF      : default number of FIR/LMS taps
//   LAT_DEF        : default MAC pipeline latency in cycles
//   tap_w()        : width of a tap index for a given tap count
package anc_pkg;

  localparam int NTAPS_DEF = 32;
  localparam int LAT_DEF   = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_FIR      = 3'd2,
    S_FIR_DRN  = 3'd3,
    S_OUT      = 3'd4,
    S_LMS      = 3'd5,
    S_LMS_DRN  = 3'd6,
    S_BYP_WAIT = 3'd7
  } state_t;

  function automatic int tap_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anc_mac_sched_if.sv
// anc_mac_sched_if -- control/status bundle between the ANC MAC scheduler
// and its surroundings.
//   inputs to scheduler : init_done, bypass_mode_sel, in_valid, bypass_ready
//   outputs             : in_ready, hist_we, tap_addr, mac_en, mac_clr,
//                         mac_sel, wt_we, wt_addr, out_valid, fir_act, busy,
//                         ovr_cnt
// Modports: master = environment side, slave = scheduler side.
interface anc_mac_sched_if
  import anc_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF
);
  localparam int AW = tap_w(NTAPS);

  logic          init_done;
  logic          bypass_mode_sel;
  logic          in_valid;
  logic          in_ready;
  logic          bypass_ready;
  logic          hist_we;
  logic [AW-1:0] tap_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_sel;
  logic          wt_we;
  logic [AW-1:0] wt_addr;
  logic          out_valid;
  logic          fir_act;
  logic          busy;
  logic [7:0]    ovr_cnt;

  modport master (
    output init_done, bypass_mode_sel, in_valid, bypass_ready,
    input  in_ready, hist_we, tap_addr, mac_en, mac_clr, mac_sel,
           wt_we, wt_addr, out_valid, fir_act, busy, ovr_cnt
  );

  modport slave (
    input  init_done, bypass_mode_sel, in_valid, bypass_ready,
    output in_ready, hist_we, tap_addr, mac_en, mac_clr, mac_sel,
           wt_we, wt_addr, out_valid, fir_act, busy, ovr_cnt
  );

endinterface

// File: rtl/anc_addr_pipe.sv
// anc_addr_pipe -- LAT-deep {valid, addr} delay line that aligns LMS weight
// write strobes with the MAC pipeline output.
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   i_valid    : LMS issue this cycle
//   i_addr     : tap index issued
//   o_valid    : i_valid delayed LAT cycles
//   o_addr     : i_addr delayed LAT cycles
module anc_addr_pipe #(
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr
);

  logic [LAT-1:0]         r_v;
  logic [LAT-1:0][AW-1:0] r_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_a <= '0;
    end else begin
      r_v[0] <= i_valid;
      r_a[0] <= i_addr;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_a[i] <= r_a[i-1];
      end
    end
  end

  assign o_valid = r_v[LAT-1];
  assign o_addr  = r_a[LAT-1];

endmodule

// File: rtl/anc_mac_sched.sv
// anc_mac_sched -- sequences one ANC sample: history load, NTAPS-tap FIR,
// pipeline drain, output strobe, then either an NTAPS-tap LMS weight update
// or a wait for NTAPS externally supplied weight words.
//   clk, rst_n : clock, async active-low reset
//   bus        : anc_mac_sched_if.slave (handshake, MAC issue, weight write,
//                status and overrun count)
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for in_valid with init_done high
// S_LOAD     | shift new x sample into history (hist_we)
// S_FIR      | issue FIR taps 0..NTAPS-1, clear accumulator on tap 0
// S_FIR_DRN  | LAT cycles for the last FIR product to land
// S_OUT      | out_valid pulse, accumulator holds the finished sample
// S_LMS      | issue LMS taps 0..NTAPS-1, weight writes trail by LAT
// S_LMS_DRN  | LAT cycles for the trailing weight writes
// S_BYP_WAIT | one weight write per bypass_ready until NTAPS written
module anc_mac_sched
  import anc_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  anc_mac_sched_if.slave bus
);

  localparam int            AW       = tap_w(NTAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [1:0]    DRN_INIT = 2'(LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_tap;
  logic [1:0]    r_drn;
  logic          r_byp;
  logic          r_iv_d;
  logic [7:0]    r_ovr;

  logic          w_accept;
  logic          w_fir_issue;
  logic          w_lms_issue;
  logic          w_mac_en;
  logic          w_byp_wr;
  logic          w_last_tap;
  logic          w_drn_done;
  logic          w_tap_inc;
  logic          w_drn_load;
  logic          w_ovr_inc;
  logic          w_pipe_valid;
  logic [AW-1:0] w_pipe_addr;

  assign w_fir_issue = (r_state == S_FIR);
  assign w_lms_issue = (r_state == S_LMS);
  assign w_mac_en    = w_fir_issue | w_lms_issue;
  assign w_byp_wr    = (r_state == S_BYP_WAIT) & bus.bypass_ready;
  assign w_last_tap  = (r_tap == LAST_TAP);
  assign w_drn_done  = (r_drn == '0);

  // rst_n gates in_ready so that nothing is offered while reset is held,
  // even though the reset state is IDLE.
  assign bus.in_ready = rst_n & bus.init_done & (r_state == S_IDLE);
  assign w_accept     = bus.in_ready & bus.in_valid;

  // The tap counter wraps to 0 on the last tap of a phase, so every phase
  // starts from tap 0 without an explicit clear.
  assign w_tap_inc  = w_mac_en | w_byp_wr;
  assign w_drn_load = w_mac_en & w_last_tap;
  assign w_ovr_inc  = bus.in_valid & ~r_iv_d & (r_state != S_IDLE) & (r_ovr != 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_drn   <= '0;
      r_byp   <= 1'b0;
      r_iv_d  <= 1'b0;
      r_ovr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_iv_d  <= bus.in_valid;
      if (w_accept) r_byp <= bus.bypass_mode_sel;
      if (w_tap_inc) r_tap <= r_tap + 1'b1;
      if (w_drn_load) r_drn <= DRN_INIT;
      else if (!w_drn_done) r_drn <= r_drn - 1'b1;
      if (w_ovr_inc) r_ovr <= r_ovr + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = S_FIR;
      S_FIR:      if (w_last_tap) w_state_nxt = S_FIR_DRN;
      S_FIR_DRN:  if (w_drn_done) w_state_nxt = S_OUT;
      S_OUT:      w_state_nxt = r_byp ? S_BYP_WAIT : S_LMS;
      S_LMS:      if (w_last_tap) w_state_nxt = S_LMS_DRN;
      S_LMS_DRN:  if (w_drn_done) w_state_nxt = S_IDLE;
      S_BYP_WAIT: if (w_byp_wr && w_last_tap) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  anc_addr_pipe #(
    .AW  (AW),
    .LAT (LAT)
  ) u_addr_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_lms_issue),
    .i_addr  (w_lms_issue ? r_tap : '0),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  assign bus.hist_we   = (r_state == S_LOAD);
  assign bus.mac_en    = w_mac_en;
  assign bus.mac_sel   = w_lms_issue;
  assign bus.mac_clr   = w_fir_issue & (r_tap == '0);
  assign bus.tap_addr  = w_mac_en ? r_tap : '0;
  // The LMS pipe and bypass writes never overlap: OUT separates them.
  assign bus.wt_we     = w_pipe_valid | w_byp_wr;
  assign bus.wt_addr   = w_byp_wr ? r_tap : (w_pipe_valid ? w_pipe_addr : '0);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.fir_act   = (r_state == S_FIR) | (r_state == S_FIR_DRN);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ovr_cnt   = r_ovr;

endmodule

// File: tb/tb_anc_mac_sched.sv
module tb_anc_mac_sched;

  localparam int NTAPS  = 32;
  localparam int LAT    = 2;
  // cycle offsets relative to the acceptance cycle
  localparam int OV_OFF = NTAPS + LAT + 2;          // out_valid
  localparam int LMS0   = NTAPS + LAT + 3;          // first LMS issue
  localparam int WT0    = LMS0 + LAT;               // first LMS weight write
  localparam int TXN    = 2 * NTAPS + 2 * LAT + 3;  // acceptance to next IDLE

  typedef struct {
    int addr;
    int cyc;   // -1: cycle not fixed (bypass writes)
  } wt_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  wt_exp_t wt_q[$];
  int      ov_q[$];
  wt_exp_t mon_e;
  int      mon_i;
  int      wt_seen = 0;
  int      lms_issue_cnt = 0;
  int      tap_idle_bad = 0;

  anc_mac_sched_if #(.NTAPS(NTAPS)) bus();

  anc_mac_sched #(.NTAPS(NTAPS), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: expectations pushed at acceptance, popped when DUT strobes
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < NTAPS; i++) begin
          mon_e.addr = i;
          mon_e.cyc  = bus.bypass_mode_sel ? -1 : cyc + WT0 + i;
          wt_q.push_back(mon_e);
        end
        ov_q.push_back(cyc + OV_OFF);
      end
      if (bus.out_valid) begin
        n_checks++;
        if (ov_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_valid_unexpected at cyc=%0d, required none", cyc);
        end else begin
          mon_i = ov_q.pop_front();
          if (cyc !== mon_i) begin
            n_fail++;
            $display("FAIL out_valid_cycle got=%0d required=%0d", cyc, mon_i);
          end
        end
      end
      if (bus.wt_we) begin
        wt_seen++;
        n_checks++;
        if (wt_q.size() == 0) begin
          n_fail++;
          $display("FAIL wt_we_unexpected addr=%0d cyc=%0d, required none", bus.wt_addr, cyc);
        end else begin
          mon_e = wt_q.pop_front();
          if (int'(bus.wt_addr) !== mon_e.addr || (mon_e.cyc >= 0 && cyc !== mon_e.cyc)) begin
            n_fail++;
            $display("FAIL wt_we addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                     bus.wt_addr, cyc, mon_e.addr, mon_e.cyc);
          end
        end
      end
      if (!bus.mac_en && bus.tap_addr !== '0) tap_idle_bad++;
      if (bus.mac_en && bus.mac_sel) lms_issue_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_timeout busy=%0b after %0d cycles, required 0", nm, bus.busy, budget);
    end
  endtask

  task automatic test_reset();
    bus.init_done       = 1'b1;
    bus.bypass_mode_sel = 1'b0;
    bus.bypass_ready    = 1'b0;
    bus.in_valid        = 1'b1;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.hist_we, bus.mac_en, bus.mac_clr, bus.mac_sel, bus.wt_we,
         bus.out_valid, bus.fir_act, bus.busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required=0", {bus.in_ready, bus.hist_we, bus.mac_en,
               bus.mac_clr, bus.mac_sel, bus.wt_we, bus.out_valid, bus.fir_act, bus.busy});
    end
    n_checks++;
    if ({bus.tap_addr, bus.wt_addr, bus.ovr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses tap=%0d wt=%0d ovr=%0d required 0", bus.tap_addr, bus.wt_addr, bus.ovr_cnt);
    end
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%0b busy=%0b required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    int c0, k, rdy_low, hist_n, hist_at, clr_n, clr_at, fir_n, fir_first;
    int seq_bad, last_wt_at, last_wt_addr, idle_at, exp_tap;
    bit exp_en, exp_sel;
    rdy_low = -1; hist_n = 0; hist_at = -1; clr_n = 0; clr_at = -1; fir_n = 0;
    fir_first = -1; seq_bad = 0; last_wt_at = -1; last_wt_addr = -1; idle_at = -1;
    step();
    bus.bypass_mode_sel = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept in_ready=%0b required 1", bus.in_ready);
    end
    for (int i = 0; i < 80; i++) begin
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      k = cyc - c0;
      if (!bus.in_ready && rdy_low < 0) rdy_low = k;
      if (bus.hist_we) begin hist_n++; hist_at = k; end
      if (bus.mac_clr) begin clr_n++; clr_at = k; end
      if (bus.fir_act) begin fir_n++; if (fir_first < 0) fir_first = k; end
      if (bus.wt_we) begin last_wt_at = k; last_wt_addr = int'(bus.wt_addr); end
      if (!bus.busy && idle_at < 0) idle_at = k;
      exp_en  = (k >= 2 && k <= NTAPS + 1) || (k >= LMS0 && k < LMS0 + NTAPS);
      exp_sel = (k >= LMS0);
      exp_tap = exp_en ? (exp_sel ? k - LMS0 : k - 2) : 0;
      if (bus.mac_en !== exp_en ||
          (exp_en && (bus.mac_sel !== exp_sel || int'(bus.tap_addr) !== exp_tap)))
        seq_bad++;
    end
    n_checks++; if (rdy_low !== 1) begin n_fail++; $display("FAIL single_rdy_drop got=%0d required=1", rdy_low); end
    n_checks++; if (hist_n !== 1 || hist_at !== 1) begin n_fail++; $display("FAIL single_hist_we n=%0d at=%0d required 1/1", hist_n, hist_at); end
    n_checks++; if (clr_n !== 1 || clr_at !== 2) begin n_fail++; $display("FAIL single_mac_clr n=%0d at=%0d required 1/2", clr_n, clr_at); end
    n_checks++; if (fir_n !== NTAPS + LAT || fir_first !== 2) begin n_fail++; $display("FAIL single_fir_act n=%0d first=%0d required %0d/2", fir_n, fir_first, NTAPS + LAT); end
    n_checks++; if (seq_bad !== 0) begin n_fail++; $display("FAIL single_mac_seq bad_cycles=%0d required 0", seq_bad); end
    n_checks++; if (last_wt_at !== 70 || last_wt_addr !== 31) begin n_fail++; $display("FAIL single_last_wt at=%0d addr=%0d required 70/31", last_wt_at, last_wt_addr); end
    n_checks++; if (idle_at !== 71) begin n_fail++; $display("FAIL single_idle got=%0d required=71", idle_at); end
    n_checks++; if (wt_q.size() !== 0 || ov_q.size() !== 0) begin n_fail++; $display("FAIL single_sb_left wt=%0d ov=%0d required 0/0", wt_q.size(), ov_q.size()); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    step();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3 * TXN + 10; k++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc.push_back(cyc);
      if (acc.size() >= 3) break;
      step();
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (acc.size() !== 3) begin
      n_fail++;
      $display("FAIL b2b_accepts got=%0d required=3", acc.size());
    end else begin
      // 70 busy cycles between acceptances, so acceptance-to-acceptance is TXN
      n_checks++;
      if (acc[1] - acc[0] !== TXN || acc[2] - acc[1] !== TXN) begin
        n_fail++;
        $display("FAIL b2b_spacing got=%0d,%0d required=%0d", acc[1] - acc[0], acc[2] - acc[1], TXN);
      end
    end
    wait_idle("b2b", TXN + 10);
    n_checks++;
    if (bus.ovr_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_ovr got=%0d required=0", bus.ovr_cnt); end
    n_checks++;
    if (wt_q.size() !== 0 || ov_q.size() !== 0) begin n_fail++; $display("FAIL b2b_sb_left wt=%0d ov=%0d required 0/0", wt_q.size(), ov_q.size()); end
  endtask

  task automatic test_bypass();
    int lms0, wt0, k;
    lms0 = lms_issue_cnt;
    wt0  = wt_seen;
    step();
    bus.bypass_mode_sel = 1'b1;
    bus.bypass_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_accept in_ready=%0b required 1", bus.in_ready); end
    k = 0;
    do begin
      step();
      bus.in_valid = 1'b0;
      bus.bypass_mode_sel = 1'b0;   // must be ignored after acceptance
      bus.bypass_ready = ~bus.bypass_ready;
      @(negedge clk);
      k++;
    end while (bus.busy && k < 300);
    step();
    bus.bypass_ready = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL byp_idle_timeout busy=%0b required 0", bus.busy); end
    n_checks++;
    if (wt_seen - wt0 !== NTAPS) begin n_fail++; $display("FAIL byp_wt_count got=%0d required=%0d", wt_seen - wt0, NTAPS); end
    n_checks++;
    if (lms_issue_cnt - lms0 !== 0) begin n_fail++; $display("FAIL byp_lms_issue got=%0d required=0", lms_issue_cnt - lms0); end
    n_checks++;
    if (wt_q.size() !== 0 || ov_q.size() !== 0) begin n_fail++; $display("FAIL byp_sb_left wt=%0d ov=%0d required 0/0", wt_q.size(), ov_q.size()); end
  endtask

  task automatic test_init_low();
    int bad_rdy, bad_act, c0, b_act, n_acc;
    bad_rdy = 0; bad_act = 0; b_act = 0; n_acc = 0;
    step();
    bus.init_done = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) bad_rdy++;
      if (bus.hist_we || bus.busy) bad_act++;
      step();
    end
    n_checks++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL init_low_rdy cycles=%0d required 0", bad_rdy); end
    n_checks++; if (bad_act !== 0) begin n_fail++; $display("FAIL init_low_act cycles=%0d required 0", bad_act); end
    bus.init_done = 1'b1;
    @(negedge clk);
    c0 = cyc;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL init_rise_accept in_ready=%0b required 1", bus.in_ready); end
    do step(); while (cyc - c0 < 10);
    bus.init_done = 1'b0;   // in_valid stays high
    wait_idle("init_mid", TXN + 10);
    n_checks++;
    if (cyc - c0 !== TXN) begin n_fail++; $display("FAIL init_mid_finish got=%0d required=%0d", cyc - c0, TXN); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy || bus.in_ready) b_act++;
      if (bus.in_valid && bus.in_ready) n_acc++;
    end
    n_checks++;
    if (b_act !== 0 || n_acc !== 0) begin n_fail++; $display("FAIL init_mid_hold act=%0d acc=%0d required 0/0", b_act, n_acc); end
    n_checks++;
    if (wt_q.size() !== 0 || ov_q.size() !== 0) begin n_fail++; $display("FAIL init_sb_left wt=%0d ov=%0d required 0/0", wt_q.size(), ov_q.size()); end
    step();
    bus.in_valid = 1'b0;
    bus.init_done = 1'b1;
  endtask

  task automatic test_ovr();
    int p, exp_ovr;
    bit prev, mid_done;
    p = 0; prev = 1'b0; mid_done = 1'b0;
    for (int k = 0; k < 3000 && p < 300; k++) begin
      step();
      if (p == 100 && !mid_done) begin
        mid_done = 1'b1;
        n_checks++;
        if (bus.ovr_cnt !== 8'd100) begin n_fail++; $display("FAIL ovr_mid got=%0d required=100", bus.ovr_cnt); end
      end
      if (prev) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1;
        if (bus.busy) p++;
      end
      prev = bus.in_valid;
    end
    step();
    bus.in_valid = 1'b0;
    wait_idle("ovr", TXN + 10);
    exp_ovr = (p > 255) ? 255 : p;
    n_checks++;
    if (int'(bus.ovr_cnt) !== exp_ovr || p !== 300) begin
      n_fail++;
      $display("FAIL ovr_sat got=%0d required=%0d pulses=%0d", bus.ovr_cnt, exp_ovr, p);
    end
  endtask

  task automatic test_reset_mid();
    int c0, wt0;
    step();
    bus.in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    step();
    bus.in_valid = 1'b0;
    while (cyc - c0 < 22) @(negedge clk);
    n_checks++;
    if (bus.mac_en !== 1'b1 || bus.tap_addr !== 5'd20) begin
      n_fail++;
      $display("FAIL rstmid_pre mac_en=%0b tap=%0d required 1/20", bus.mac_en, bus.tap_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.hist_we, bus.mac_en, bus.mac_clr, bus.mac_sel, bus.wt_we, bus.out_valid,
         bus.fir_act, bus.busy, bus.tap_addr, bus.wt_addr, bus.ovr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs tap=%0d ovr=%0d busy=%0b fir_act=%0b required all 0",
               bus.tap_addr, bus.ovr_cnt, bus.busy, bus.fir_act);
    end
    wt_q.delete();
    ov_q.delete();
    wt0 = wt_seen;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (wt_seen - wt0 !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after wt_we=%0d busy=%0b required 0/0", wt_seen - wt0, bus.busy);
    end
    step();
    bus.in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart in_ready=%0b required 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    wait_idle("rstmid", TXN + 10);
    n_checks++;
    if (cyc - c0 !== TXN) begin n_fail++; $display("FAIL rstmid_txn_len got=%0d required=%0d", cyc - c0, TXN); end
    n_checks++;
    if (wt_q.size() !== 0 || ov_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_sb_left wt=%0d ov=%0d required 0/0", wt_q.size(), ov_q.size()); end
  endtask

  task automatic test_tap_idle();
    n_checks++;
    if (tap_idle_bad !== 0) begin n_fail++; $display("FAIL tap_idle nonzero_cycles=%0d required 0", tap_idle_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_init_low();
    test_ovr();
    test_reset_mid();
    test_tap_idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
